// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - arbitrates the instruction and data ports onto one single-port SRAM
//
// Purpose: each cycle grants at most one of the two ports and steers that port's
// address, byte enables and write data to the SRAM. Read data returns to the owning
// port one cycle later, and each port keeps its last returned word until its next return.
// Data normally wins a contested cycle. After STARVE_LIMIT consecutive contested data
// wins, the instruction port is forced through.
//
// Ports:
//   clk, rst                        clock; asynchronous active-low reset
//   inst_req/wen/addr/wdata         instruction port request side
//   inst_gnt/rvalid/rdata           instruction port grant and return side
//   data_req/wen/addr/wdata         data port request side
//   data_gnt/rvalid/rdata           data port grant and return side
//   mem_en/wen/addr/wdata/rdata     SRAM interface (rdata valid the cycle after a read)
//   stallreq                        a request was refused this cycle
//   starve_cnt                      consecutive contested data wins (debug)

module sram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [3:0]        inst_wen,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_gnt,
  output logic              inst_rvalid,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stallreq,
  output logic [3:0]        starve_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;   // 1 = data port owns the pending return
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0] inst_hold_q, inst_hold_d;
  logic [DATA_W-1:0] data_hold_q, data_hold_d;

  logic inst_ret, data_ret;

  always_comb begin
    inst_gnt     = 1'b0;
    data_gnt     = 1'b0;
    mem_en       = 1'b0;
    mem_wen      = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    stallreq     = 1'b0;
    starve_cnt_d = starve_cnt_q;
    rd_pend_d    = 1'b0;
    rd_owner_d   = rd_owner_q;

    // Grants are also gated by reset so nothing reaches the SRAM while in reset.
    if (rst) begin
      data_gnt = data_req & (~inst_req | (starve_cnt_q < LIMIT));
      inst_gnt = inst_req & ~data_gnt;
    end

    if (inst_gnt) begin
      mem_en    = 1'b1;
      mem_wen   = inst_wen;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end else if (data_gnt) begin
      mem_en    = 1'b1;
      mem_wen   = data_wen;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end

    if (rst) begin
      stallreq = (inst_req & ~inst_gnt) | (data_req & ~data_gnt);
    end

    if (inst_gnt) begin
      starve_cnt_d = '0;
    end else if (data_gnt && inst_req && (starve_cnt_q < LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    // Writes produce no return; only a granted read schedules one.
    if (mem_en && (mem_wen == 4'd0)) begin
      rd_pend_d  = 1'b1;
      rd_owner_d = data_gnt;
    end
  end

  assign inst_ret = rd_pend_q & ~rd_owner_q;
  assign data_ret = rd_pend_q &  rd_owner_q;

  // Each hold register follows only its own port's returns.
  always_comb begin
    inst_hold_d = inst_ret ? mem_rdata : inst_hold_q;
    data_hold_d = data_ret ? mem_rdata : data_hold_q;
  end

  assign inst_rvalid = inst_ret;
  assign data_rvalid = data_ret;
  assign inst_rdata  = inst_ret ? mem_rdata : inst_hold_q;
  assign data_rdata  = data_ret ? mem_rdata : data_hold_q;
  assign starve_cnt  = starve_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
      starve_cnt_q <= '0;
      inst_hold_q  <= '0;
      data_hold_q  <= '0;
    end else begin
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      starve_cnt_q <= starve_cnt_d;
      inst_hold_q  <= inst_hold_d;
      data_hold_q  <= data_hold_d;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed self-checking bench for sram_port_arbiter
//
// Purpose: drives directed request/SRAM-return vectors and compares every observed
// output against hand-computed values.
// Ports: none (top-level bench).

module tb_sram_port_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [3:0]  inst_wen;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stallreq;
  logic [3:0]  starve_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  sram_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .inst_req(inst_req),
    .inst_wen(inst_wen),
    .inst_addr(inst_addr),
    .inst_wdata(inst_wdata),
    .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid),
    .inst_rdata(inst_rdata),
    .data_req(data_req),
    .data_wen(data_wen),
    .data_addr(data_addr),
    .data_wdata(data_wdata),
    .data_gnt(data_gnt),
    .data_rvalid(data_rvalid),
    .data_rdata(data_rdata),
    .mem_en(mem_en),
    .mem_wen(mem_wen),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stallreq(stallreq),
    .starve_cnt(starve_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic       exp_dwin [6];
  logic [3:0] exp_cnt  [6];

  initial begin
    exp_dwin = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_cnt  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};

    rst = 1'b0;
    inst_req = 1'b1; inst_wen = 4'd0; inst_addr = 32'h40; inst_wdata = '0;
    data_req = 1'b1; data_wen = 4'd0; data_addr = 32'h80; data_wdata = '0;
    mem_rdata = 32'h0;

    // Reset state: requests present but nothing granted or stalled.
    #3;
    chk("rst_inst_gnt", {31'd0, inst_gnt}, 32'd0);
    chk("rst_data_gnt", {31'd0, data_gnt}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_stallreq", {31'd0, stallreq}, 32'd0);
    chk("rst_inst_rvalid", {31'd0, inst_rvalid}, 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);
    chk("rst_starve", {28'd0, starve_cnt}, 32'd0);

    // Single instruction read; first grant in the first cycle out of reset.
    @(negedge clk);
    rst = 1'b1;
    data_req = 1'b0;
    inst_req = 1'b1; inst_addr = 32'hBFC00000;
    #1;
    chk("ird_gnt", {31'd0, inst_gnt}, 32'd1);
    chk("ird_mem_en", {31'd0, mem_en}, 32'd1);
    chk("ird_mem_addr", mem_addr, 32'hBFC00000);
    chk("ird_mem_wen", {28'd0, mem_wen}, 32'd0);
    chk("ird_stall", {31'd0, stallreq}, 32'd0);
    @(negedge clk);
    inst_req = 1'b0;
    mem_rdata = 32'h24010001;
    #1;
    chk("ird_rvalid", {31'd0, inst_rvalid}, 32'd1);
    chk("ird_rdata", inst_rdata, 32'h24010001);
    chk("ird_data_rvalid", {31'd0, data_rvalid}, 32'd0);
    chk("idle_mem_en", {31'd0, mem_en}, 32'd0);
    chk("idle_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    mem_rdata = 32'h12345678;
    #1;
    chk("ird_hold_rvalid", {31'd0, inst_rvalid}, 32'd0);
    chk("ird_hold_rdata", inst_rdata, 32'h24010001);

    // Contention and starvation: both held 6 cycles, expect D,D,D,D,I,D.
    mem_rdata = 32'hC0DE0000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      inst_req = 1'b1; inst_addr = 32'h100;
      data_req = 1'b1; data_addr = 32'h200;
      #1;
      chk($sformatf("cont%0d_data_gnt", k), {31'd0, data_gnt}, {31'd0, exp_dwin[k]});
      chk($sformatf("cont%0d_inst_gnt", k), {31'd0, inst_gnt}, {31'd0, ~exp_dwin[k]});
      chk($sformatf("cont%0d_addr", k), mem_addr, exp_dwin[k] ? 32'h200 : 32'h100);
      chk($sformatf("cont%0d_stall", k), {31'd0, stallreq}, 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("cont%0d_starve", k), {28'd0, starve_cnt}, {28'd0, exp_cnt[k]});
    end
    @(negedge clk);
    inst_req = 1'b0; data_req = 1'b0;
    mem_rdata = 32'h00005A5A;
    #1;
    chk("cont_dret_rvalid", {31'd0, data_rvalid}, 32'd1);
    chk("cont_dret_rdata", data_rdata, 32'h00005A5A);
    chk("cont_inst_hold", inst_rdata, 32'hC0DE0000);
    chk("cont_stall_idle", {31'd0, stallreq}, 32'd0);

    // Data write: no return, hold value kept.
    @(negedge clk);
    data_req = 1'b1; data_wen = 4'hF; data_addr = 32'h10; data_wdata = 32'hDEADBEEF;
    #1;
    chk("wr_gnt", {31'd0, data_gnt}, 32'd1);
    chk("wr_mem_wen", {28'd0, mem_wen}, 32'hF);
    chk("wr_mem_addr", mem_addr, 32'h10);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    data_req = 1'b0; data_wen = 4'd0;
    mem_rdata = 32'h11111111;
    #1;
    chk("wr_no_rvalid", {31'd0, data_rvalid}, 32'd0);
    chk("wr_hold", data_rdata, 32'h00005A5A);

    // Hold isolation with back-to-back inst read then data read.
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h300;
    #1;
    chk("iso_inst_gnt", {31'd0, inst_gnt}, 32'd1);
    @(negedge clk);
    inst_req = 1'b0;
    data_req = 1'b1; data_addr = 32'h400;
    mem_rdata = 32'hAAAA0000;
    #1;
    chk("iso_irv", {31'd0, inst_rvalid}, 32'd1);
    chk("iso_ird", inst_rdata, 32'hAAAA0000);
    chk("iso_dgnt", {31'd0, data_gnt}, 32'd1);
    chk("iso_dhold", data_rdata, 32'h00005A5A);
    @(negedge clk);
    data_req = 1'b0;
    mem_rdata = 32'h00005555;
    #1;
    chk("iso_drv", {31'd0, data_rvalid}, 32'd1);
    chk("iso_drd", data_rdata, 32'h00005555);
    chk("iso_irv_off", {31'd0, inst_rvalid}, 32'd0);
    chk("iso_ird_kept", inst_rdata, 32'hAAAA0000);
    @(negedge clk);
    mem_rdata = 32'h77777777;
    #1;
    chk("iso_dhold2", data_rdata, 32'h00005555);
    chk("iso_ihold2", inst_rdata, 32'hAAAA0000);

    // Build starve_cnt up so reset clearing it is visible.
    @(negedge clk);
    inst_req = 1'b1; data_req = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst_starve", {28'd0, starve_cnt}, 32'd1);

    // Reset mid-read: inst read granted in N, reset asserted inside N.
    @(negedge clk);
    data_req = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h500;
    #1;
    chk("rmr_gnt", {31'd0, inst_gnt}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("rmr_gnt_rst", {31'd0, inst_gnt}, 32'd0);
    chk("rmr_stall", {31'd0, stallreq}, 32'd0);
    chk("rmr_ird", inst_rdata, 32'd0);
    chk("rmr_drd", data_rdata, 32'd0);
    chk("rmr_starve", {28'd0, starve_cnt}, 32'd0);
    @(negedge clk);
    inst_req = 1'b0;
    rst = 1'b1;
    mem_rdata = 32'h99999999;
    #1;
    chk("rmr_no_rvalid", {31'd0, inst_rvalid}, 32'd0);
    chk("rmr_ird_after", inst_rdata, 32'd0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-port synchronous SRAM between the IF-stage instruction port and the EX-stage data port of the five-stage core. Each cycle it grants at most one requester, steers that requester's address, write-enable and write data to the memory, and routes the read data back to the owning port one cycle later. It holds returned read data stable while the pipeline is stalled. It also raises a stall request to CTRL whenever a request is refused.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive contested data wins before the instruction port is forced through (1..15)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- inst_req  in  1  instruction access request (level, held until granted)
- inst_wen  in  4  instruction byte write enables (normally 0)
- inst_addr  in  ADDR_W  instruction address
- inst_wdata  in  DATA_W  instruction write data
- inst_gnt  out  1  instruction access issued this cycle
- inst_rvalid  out  1  inst_rdata carries fresh memory data this cycle
- inst_rdata  out  DATA_W  instruction read data (fresh or held)
- data_req, data_wen, data_addr, data_wdata  in  1/4/ADDR_W/DATA_W  data-port equivalents
- data_gnt, data_rvalid, data_rdata  out  1/1/DATA_W  data-port equivalents
- mem_en  out  1  SRAM enable
- mem_wen  out  4  SRAM byte write enables
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid the cycle after a read access
- stallreq  out  1  to CTRL: a request was refused this cycle
- starve_cnt  out  4  current consecutive-contested-data-win count (debug)

## Operation
- Grant logic is combinational from the req inputs and registered starve_cnt:
  - Only one request: it is granted.
  - Both requests: data wins if starve_cnt < STARVE_LIMIT, otherwise inst wins.
  - No request: no grant; mem_en=0, mem_wen=0, mem_addr/mem_wdata=0.
- Memory steering: mem_en=1 on any grant; mem_wen/addr/wdata come from the granted port.
- stallreq = (inst_req & ~inst_gnt) | (data_req & ~data_gnt).
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on a data grant while inst_req=1.
  - Clears to 0 on any inst grant.
  - Otherwise holds.
- Return-owner registers: on a grant with wen==0, rd_owner ← granted port and rd_pend ← 1. Otherwise rd_pend ← 0. Writes produce no return.
- Return cycle (rd_pend=1): the owner's rvalid=1 and its rdata = mem_rdata. The owner's hold register captures mem_rdata at that clock edge.
- Otherwise rdata = that port's hold register and rvalid=0. A hold register changes only on its own port's return cycle; the other port's traffic never disturbs it.
- Same-address write then read, across ports or within one port, needs no forwarding: the SRAM resolves it sequentially.

## Timing
- Grant: 0 cycles, combinational, in the request cycle N.
- Read data: cycle N+1 on the owner port with rvalid=1; held value from N+2 onward.
- Back-to-back grants are allowed every cycle. A return in N+1 and a new grant in N+1 coexist.
- Reset (rst=0, asynchronous):
  - Forced to 0: rd_pend, rd_owner, both hold registers, starve_cnt, so inst_rvalid = data_rvalid = 0 and inst_rdata = data_rdata = 0.
  - Grants and mem_* stay combinational: while rst=0 they are additionally forced to 0 and stallreq is forced to 0.
- Reset mid-read: the pending return is dropped and no rvalid follows.
- Reset deassertion: the first grant is possible in the first cycle with rst=1.
- STARVE_LIMIT=1: contested cycles alternate data, inst, data, inst, ...

## Test plan
- Single inst read: inst_req=1, addr=0xBFC00000, mem returns 0x24010001 → inst_gnt=1 and mem_addr=0xBFC00000 in N. inst_rvalid=1 and inst_rdata=0x24010001 in N+1. Value held in N+2 with rvalid=0.
- Contention: both req at 0x100 (inst) and 0x200 (data) → data_gnt=1, inst_gnt=0, stallreq=1, mem_addr=0x200, starve_cnt 0→1.
- Starvation: both req held 6 cycles, STARVE_LIMIT=4 → grants D,D,D,D,I,D; starve_cnt 1,2,3,4,0,1. stallreq=1 every cycle.
- Data write: data_req=1, wen=0xF, addr=0x10, wdata=0xDEADBEEF → mem_wen=0xF, data_rvalid stays 0 in N+1, data_rdata keeps its prior hold value.
- Hold isolation: inst read returns 0xAAAA0000, then data read returns 0x5555 → inst_rdata stays 0xAAAA0000 through the data return.
- Reset mid-read: grant an inst read in N, rst=0 asynchronously during N → no inst_rvalid in N+1, both rdata=0, starve_cnt=0, stallreq=0 during reset.
